axi4_lite_reg_bridge: RTL and testbench
=======================================

Name: axi4_lite_reg_bridge

Overview:
AXI4-Lite slave-side bridge that terminates the five AXI4-Lite channels and converts each transaction into a single request/acknowledge access on a simple native register bus. It sits at the responder end of an axi4_lite_master, in place of or beside axi4_lite_slave. It decodes a base/span window and returns DECERR outside it. A per-access timeout returns SLVERR when the register bus never acknowledges.

Parameters:
DATA_WIDTH, 32, AXI and register data width (multiple of 8)
ADDRESS, 32, AXI and register address width
BASE_ADDR, 32'h0000_0000, first byte address of decoded window
ADDR_SPAN, 32'h0000_1000, window size in bytes
TIMEOUT, 16, cycles REG_REQ may stay high without REG_ACK (>=2)

Ports:
ACLK  in  1  clock, rising edge
ARESETN  in  1  asynchronous active-low reset
S_AWADDR  in  ADDRESS  write address
S_AWVALID  in  1  write address valid
S_AWREADY  out  1  write address ready
S_WDATA  in  DATA_WIDTH  write data
S_WSTRB  in  DATA_WIDTH/8  byte strobes
S_WVALID  in  1  write data valid
S_WREADY  out  1  write data ready
S_BRESP  out  2  write response
S_BVALID  out  1  write response valid
S_BREADY  in  1  write response ready
S_ARADDR  in  ADDRESS  read address
S_ARVALID  in  1  read address valid
S_ARREADY  out  1  read address ready
S_RDATA  out  DATA_WIDTH  read data
S_RRESP  out  2  read response
S_RVALID  out  1  read valid
S_RREADY  in  1  read ready
REG_REQ  out  1  register access request
REG_WE  out  1  1=write, 0=read
REG_ADDR  out  ADDRESS  offset = addr - BASE_ADDR
REG_WDATA  out  DATA_WIDTH  write data
REG_WSTRB  out  DATA_WIDTH/8  byte strobes
REG_ACK  in  1  access complete
REG_RDATA  in  DATA_WIDTH  read data, valid with REG_ACK
REG_ERR  in  1  access error, valid with REG_ACK

Behaviour:
- Reset (ARESETN low, async): all outputs 0. FSM goes to IDLE. AW/W capture flags are cleared. Timeout counter is 0. Round-robin flag is set to read-first.
- FSM states: IDLE, REG_WR, WR_RESP, REG_RD, RD_RESP.
- IDLE, AW and W channels:
  - S_AWREADY=1 while no AW is captured; S_WREADY=1 while no W is captured.
  - AW and W may arrive in either order or in the same cycle.
  - Each is registered on its own handshake.
- IDLE, AR channel: S_ARREADY=1 only when neither AW nor W is captured.
- Arbitration in IDLE with nothing captured:
  - ARVALID together with AWVALID or WVALID: the grant goes to the side not served last.
  - The losing side's READY is 0 that cycle.
- Write completion: with both AW and W held, decode and branch.
  - In window: go to REG_WR; REG_REQ=1, REG_WE=1, with address offset, data and strobes, in the next cycle.
  - Out of window: go to WR_RESP with BRESP=2'b11; no REG_REQ is issued.
- Read: on AR handshake, decode and branch.
  - In window: go to REG_RD, REG_REQ=1, REG_WE=0.
  - Out of window: go to RD_RESP, RRESP=2'b11, RDATA=0.
- REG_REQ and all REG_* outputs stay stable until REG_ACK is sampled high, including an ACK in the first REQ cycle.
  - REG_REQ drops in the cycle after ACK.
  - The response is OKAY (2'b00), or SLVERR (2'b10) if REG_ERR=1.
  - For reads, RDATA captures REG_RDATA (0 on error).
- Timeout:
  - The counter clears when REG_REQ rises and increments on every cycle without ACK.
  - On the cycle where count==TIMEOUT-1 and there is still no ACK, REG_REQ drops and the response is SLVERR (RDATA=0).
  - A late REG_ACK in IDLE or a response state is ignored.
- WR_RESP: BVALID=1, BRESP stable until BREADY. On BVALID&BREADY, BVALID drops next cycle, capture flags clear, return to IDLE.
- RD_RESP: RVALID=1, RDATA and RRESP stable until RREADY, then return to IDLE.
- Latency with zero backpressure and REG_ACK in the first REQ cycle:
  - Address handshake at cycle 0, REG_REQ at cycle 1, B/RVALID at cycle 2.
  - DECERR: B/RVALID at cycle 1.
- One outstanding transaction at a time. No new AR/AW/W is accepted until the response handshake completes.
- In-window test: ADDR >= BASE_ADDR and (ADDR - BASE_ADDR) < ADDR_SPAN. Arithmetic is ADDRESS bits wide, unsigned.
- Reset mid-operation drops REG_REQ and B/RVALID immediately and discards any captured AW/W.

Decomposition:
- Shared package axi4_lite_pkg:
  - resp_t with RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - State enum bridge_state_t.
- axi4_lite_master and axi4_lite_slave also import axi4_lite_pkg.
- No sub-module. The timeout counter and decode are inline.

Test Plan:
- Write: AW=0x10 and W=0xDEADBEEF with STRB=4'hF in the same cycle, REG_ACK two cycles after REQ -> REG_ADDR=0x10, REG_WDATA=0xDEADBEEF, REG_WE=1; BVALID with BRESP=00 one cycle after ACK.
- Read: AR=0x24, REG_RDATA=0x12345678 with ACK in the first cycle -> RVALID at cycle 2, RDATA=0x12345678, RRESP=00.
- W before AW (W at cycle 0, AW at cycle 3) and write to 0x2000 (out of window) -> no REG_REQ; BRESP=11 one cycle after AW.
- Never-acked read at 0x4 -> REG_REQ high exactly TIMEOUT cycles; RRESP=10, RDATA=0; a late ACK is ignored.
- AR and AW+W valid together from reset -> read served first, write second. Next simultaneous pair: write first. REG_ERR=1 on the write -> BRESP=10.
- BREADY held low 5 cycles, then ARESETN pulsed low mid-REG_RD -> BVALID and BRESP stable while BREADY is low. During the reset: all outputs 0, REG_REQ low. After reset: a clean read completes with OKAY.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// ============================================================================
// Module  : axi4_lite_pkg
// Brief   : Shared AXI4-Lite response codes and register-bridge state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package axi4_lite_pkg;

  // AXI4-Lite response encodings used by the bridge.
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  // Bridge control states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REG_WR  = 3'd1,
    WR_RESP = 3'd2,
    REG_RD  = 3'd3,
    RD_RESP = 3'd4
  } bridge_state_t;

endpackage

`default_nettype wire

// File: rtl/axi4_lite_reg_bridge_if.sv
// ============================================================================
// Module  : axi4_lite_reg_bridge_if
// Brief   : AXI4-Lite slave channels plus native register bus of the bridge.
//           slave modport = bridge side, master modport = AXI initiator and
//           register responder side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi4_lite_reg_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS    = 32
) ();

  // AXI4-Lite write address / data / response
  logic [ADDRESS-1:0]      S_AWADDR;
  logic                    S_AWVALID;
  logic                    S_AWREADY;
  logic [DATA_WIDTH-1:0]   S_WDATA;
  logic [DATA_WIDTH/8-1:0] S_WSTRB;
  logic                    S_WVALID;
  logic                    S_WREADY;
  logic [1:0]              S_BRESP;
  logic                    S_BVALID;
  logic                    S_BREADY;
  // AXI4-Lite read address / data
  logic [ADDRESS-1:0]      S_ARADDR;
  logic                    S_ARVALID;
  logic                    S_ARREADY;
  logic [DATA_WIDTH-1:0]   S_RDATA;
  logic [1:0]              S_RRESP;
  logic                    S_RVALID;
  logic                    S_RREADY;
  // Native register bus
  logic                    REG_REQ;
  logic                    REG_WE;
  logic [ADDRESS-1:0]      REG_ADDR;
  logic [DATA_WIDTH-1:0]   REG_WDATA;
  logic [DATA_WIDTH/8-1:0] REG_WSTRB;
  logic                    REG_ACK;
  logic [DATA_WIDTH-1:0]   REG_RDATA;
  logic                    REG_ERR;

  modport slave (
    input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
    input  S_ARADDR, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    output S_ARREADY, S_RDATA, S_RRESP, S_RVALID,
    output REG_REQ, REG_WE, REG_ADDR, REG_WDATA, REG_WSTRB,
    input  REG_ACK, REG_RDATA, REG_ERR
  );

  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
    output S_ARADDR, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    input  S_ARREADY, S_RDATA, S_RRESP, S_RVALID,
    input  REG_REQ, REG_WE, REG_ADDR, REG_WDATA, REG_WSTRB,
    output REG_ACK, REG_RDATA, REG_ERR
  );

endinterface

`default_nettype wire

// File: rtl/axi4_lite_reg_bridge.sv
// ============================================================================
// Module  : axi4_lite_reg_bridge
// Brief   : AXI4-Lite slave that turns each transaction into one req/ack
//           access on a native register bus, with window decode (DECERR)
//           and a per-access acknowledge timeout (SLVERR).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_lite_reg_bridge
  import axi4_lite_pkg::*;
#(
  parameter int                 DATA_WIDTH = 32,
  parameter int                 ADDRESS    = 32,
  parameter logic [ADDRESS-1:0] BASE_ADDR  = ADDRESS'(32'h0000_0000),
  parameter logic [ADDRESS-1:0] ADDR_SPAN  = ADDRESS'(32'h0000_1000),
  parameter int                 TIMEOUT    = 16
) (
  input wire                    ACLK,
  input wire                    ARESETN,
  axi4_lite_reg_bridge_if.slave bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  bridge_state_t           state_q, state_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [ADDRESS-1:0]      awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    read_first_q, read_first_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [ADDRESS-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   reg_wdata_q, reg_wdata_d;
  logic [STRB_W-1:0]       reg_wstrb_q, reg_wstrb_d;
  logic                    bvalid_q, bvalid_d;
  resp_t                   bresp_q, bresp_d;
  logic                    rvalid_q, rvalid_d;
  resp_t                   rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]        tcount_q, tcount_d;

  logic                    awready, wready, arready;
  logic                    nothing_held, contention;
  logic                    aw_hs, w_hs, ar_hs;
  logic [ADDRESS-1:0]      wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [STRB_W-1:0]       wr_strb;
  resp_t                   done_resp;

  function automatic logic in_window(input logic [ADDRESS-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < ADDR_SPAN);
  endfunction

  // Next-state, channel readiness and next register-bus/response values.
  always_comb begin
    state_d      = state_q;
    aw_held_d    = aw_held_q;
    w_held_d     = w_held_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    read_first_d = read_first_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_wstrb_d  = reg_wstrb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    rvalid_d     = rvalid_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    tcount_d     = tcount_q;
    awready      = 1'b0;
    wready       = 1'b0;
    arready      = 1'b0;
    nothing_held = !aw_held_q && !w_held_q;
    contention   = 1'b0;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    ar_hs        = 1'b0;
    wr_addr      = aw_held_q ? awaddr_q : bus.S_AWADDR;
    wr_data      = w_held_q ? wdata_q : bus.S_WDATA;
    wr_strb      = w_held_q ? wstrb_q : bus.S_WSTRB;
    done_resp    = (!bus.REG_ACK || bus.REG_ERR) ? RESP_SLVERR : RESP_OKAY;

    case (state_q)
      IDLE: begin
        // The round-robin flag only moves when both sides actually compete,
        // so an uncontended transaction does not steal the next turn.
        contention = nothing_held && bus.S_ARVALID && (bus.S_AWVALID || bus.S_WVALID);
        arready = nothing_held && !(contention && !read_first_q);
        awready = !aw_held_q && !(contention && read_first_q);
        wready  = !w_held_q && !(contention && read_first_q);
        aw_hs   = awready && bus.S_AWVALID;
        w_hs    = wready && bus.S_WVALID;
        ar_hs   = arready && bus.S_ARVALID;
        if (contention) read_first_d = !read_first_q;
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = bus.S_AWADDR;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = bus.S_WDATA;
          wstrb_d  = bus.S_WSTRB;
        end
        if (ar_hs) begin
          if (in_window(bus.S_ARADDR)) begin
            state_d  = REG_RD;
            req_d    = 1'b1;
            we_d     = 1'b0;
            addr_d   = bus.S_ARADDR - BASE_ADDR;
            tcount_d = '0;
          end else begin
            state_d  = RD_RESP;
            rvalid_d = 1'b1;
            rresp_d  = RESP_DECERR;
            rdata_d  = '0;
          end
        end else if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          if (in_window(wr_addr)) begin
            state_d     = REG_WR;
            req_d       = 1'b1;
            we_d        = 1'b1;
            addr_d      = wr_addr - BASE_ADDR;
            reg_wdata_d = wr_data;
            reg_wstrb_d = wr_strb;
            tcount_d    = '0;
          end else begin
            state_d  = WR_RESP;
            bvalid_d = 1'b1;
            bresp_d  = RESP_DECERR;
          end
        end
      end
      REG_WR, REG_RD: begin
        // Finish on acknowledge, or give up on the last allowed cycle.
        if (bus.REG_ACK || (tcount_q == CNT_LAST)) begin
          req_d = 1'b0;
          if (state_q == REG_WR) begin
            state_d  = WR_RESP;
            bvalid_d = 1'b1;
            bresp_d  = done_resp;
          end else begin
            state_d  = RD_RESP;
            rvalid_d = 1'b1;
            rresp_d  = done_resp;
            rdata_d  = (done_resp == RESP_OKAY) ? bus.REG_RDATA : '0;
          end
        end else begin
          tcount_d = tcount_q + CNT_W'(1);
        end
      end
      WR_RESP: begin
        if (bus.S_BREADY) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      RD_RESP: begin
        if (bus.S_RREADY) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= IDLE;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      read_first_q <= 1'b1;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      reg_wdata_q  <= '0;
      reg_wstrb_q  <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
      tcount_q     <= '0;
    end else begin
      state_q      <= state_d;
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      read_first_q <= read_first_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_wstrb_q  <= reg_wstrb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      tcount_q     <= tcount_d;
    end
  end

  // Ready outputs are forced low while reset is asserted.
  assign bus.S_AWREADY = ARESETN & awready;
  assign bus.S_WREADY  = ARESETN & wready;
  assign bus.S_ARREADY = ARESETN & arready;
  assign bus.S_BVALID  = bvalid_q;
  assign bus.S_BRESP   = bresp_q;
  assign bus.S_RVALID  = rvalid_q;
  assign bus.S_RRESP   = rresp_q;
  assign bus.S_RDATA   = rdata_q;
  assign bus.REG_REQ   = req_q;
  assign bus.REG_WE    = we_q;
  assign bus.REG_ADDR  = addr_q;
  assign bus.REG_WDATA = reg_wdata_q;
  assign bus.REG_WSTRB = reg_wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_reg_bridge.sv
// ============================================================================
// Module  : tb_axi4_lite_reg_bridge
// Brief   : Directed self-checking bench for axi4_lite_reg_bridge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4_lite_reg_bridge;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   req_cycles;

  axi4_lite_reg_bridge_if #(.DATA_WIDTH(32), .ADDRESS(32)) bus ();

  axi4_lite_reg_bridge #(
    .DATA_WIDTH(32), .ADDRESS(32), .BASE_ADDR(32'h0), .ADDR_SPAN(32'h1000), .TIMEOUT(16)
  ) dut (
    .ACLK   (clk),
    .ARESETN(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, bus.S_AWREADY, 0);
    chk({tag, "_wready"},  bus.S_WREADY,  0);
    chk({tag, "_arready"}, bus.S_ARREADY, 0);
    chk({tag, "_bvalid"},  bus.S_BVALID,  0);
    chk({tag, "_bresp"},   bus.S_BRESP,   0);
    chk({tag, "_rvalid"},  bus.S_RVALID,  0);
    chk({tag, "_rresp"},   bus.S_RRESP,   0);
    chk({tag, "_rdata"},   bus.S_RDATA,   0);
    chk({tag, "_req"},     bus.REG_REQ,   0);
    chk({tag, "_we"},      bus.REG_WE,    0);
    chk({tag, "_addr"},    bus.REG_ADDR,  0);
    chk({tag, "_wdata"},   bus.REG_WDATA, 0);
    chk({tag, "_wstrb"},   bus.REG_WSTRB, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.S_AWADDR = '0; bus.S_AWVALID = 0; bus.S_WDATA = '0; bus.S_WSTRB = '0;
    bus.S_WVALID = 0; bus.S_BREADY = 0; bus.S_ARADDR = '0; bus.S_ARVALID = 0;
    bus.S_RREADY = 0; bus.REG_ACK = 0; bus.REG_RDATA = '0; bus.REG_ERR = 0;

    // Reset state
    tick(); tick();
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick();
    chk("idle_awready", bus.S_AWREADY, 1);
    chk("idle_arready", bus.S_ARREADY, 1);

    // Write 0x10 <= DEADBEEF, AW and W together, ACK two cycles after REQ
    bus.S_AWADDR = 32'h10; bus.S_AWVALID = 1;
    bus.S_WDATA = 32'hDEAD_BEEF; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1;
    #1;
    chk("wr1_awready", bus.S_AWREADY, 1);
    chk("wr1_wready",  bus.S_WREADY,  1);
    tick();
    bus.S_AWVALID = 0; bus.S_WVALID = 0;
    chk("wr1_req",   bus.REG_REQ,   1);
    chk("wr1_we",    bus.REG_WE,    1);
    chk("wr1_addr",  bus.REG_ADDR,  32'h10);
    chk("wr1_wdata", bus.REG_WDATA, 32'hDEAD_BEEF);
    chk("wr1_wstrb", bus.REG_WSTRB, 4'hF);
    tick();
    chk("wr1_req_hold",  bus.REG_REQ,   1);
    chk("wr1_busy_awr",  bus.S_AWREADY, 0);
    chk("wr1_busy_arr",  bus.S_ARREADY, 0);
    tick();
    chk("wr1_addr_hold", bus.REG_ADDR, 32'h10);
    bus.REG_ACK = 1;
    tick();
    bus.REG_ACK = 0;
    chk("wr1_req_drop", bus.REG_REQ,  0);
    chk("wr1_bvalid",   bus.S_BVALID, 1);
    chk("wr1_bresp",    bus.S_BRESP,  2'b00);
    bus.S_BREADY = 1;
    tick();
    bus.S_BREADY = 0;
    chk("wr1_bvalid_drop", bus.S_BVALID, 0);

    // Read 0x24, ACK in the first REQ cycle
    bus.S_ARADDR = 32'h24; bus.S_ARVALID = 1;
    #1;
    chk("rd1_arready", bus.S_ARREADY, 1);
    tick();
    bus.S_ARVALID = 0;
    chk("rd1_req",  bus.REG_REQ,  1);
    chk("rd1_we",   bus.REG_WE,   0);
    chk("rd1_addr", bus.REG_ADDR, 32'h24);
    chk("rd1_rvalid_early", bus.S_RVALID, 0);
    bus.REG_ACK = 1; bus.REG_RDATA = 32'h1234_5678;
    tick();
    bus.REG_ACK = 0; bus.REG_RDATA = '0;
    chk("rd1_req_drop", bus.REG_REQ,  0);
    chk("rd1_rvalid",   bus.S_RVALID, 1);
    chk("rd1_rdata",    bus.S_RDATA,  32'h1234_5678);
    chk("rd1_rresp",    bus.S_RRESP,  2'b00);
    bus.S_RREADY = 1;
    tick();
    bus.S_RREADY = 0;
    chk("rd1_rvalid_drop", bus.S_RVALID, 0);

    // W first, AW three cycles later, out-of-window address
    bus.S_WDATA = 32'h0BAD_F00D; bus.S_WSTRB = 4'h3; bus.S_WVALID = 1;
    #1;
    chk("dec_wready", bus.S_WREADY, 1);
    tick();
    bus.S_WVALID = 0;
    chk("dec_wready_held", bus.S_WREADY,  0);
    chk("dec_awready",     bus.S_AWREADY, 1);
    chk("dec_arready_blk", bus.S_ARREADY, 0);
    tick(); tick();
    bus.S_AWADDR = 32'h2000; bus.S_AWVALID = 1;
    tick();
    bus.S_AWVALID = 0;
    chk("dec_no_req", bus.REG_REQ,  0);
    chk("dec_bvalid", bus.S_BVALID, 1);
    chk("dec_bresp",  bus.S_BRESP,  2'b11);
    bus.S_BREADY = 1;
    tick();
    bus.S_BREADY = 0;
    chk("dec_bvalid_drop", bus.S_BVALID,  0);
    chk("dec_flags_clear", bus.S_ARREADY, 1);

    // Never-acknowledged read at 0x4 times out after TIMEOUT cycles
    bus.S_ARADDR = 32'h4; bus.S_ARVALID = 1;
    tick();
    bus.S_ARVALID = 0;
    req_cycles = 0;
    for (int i = 0; i < 40 && bus.REG_REQ; i++) begin
      req_cycles++;
      tick();
    end
    chk("to_req_cycles", req_cycles, 16);
    chk("to_rvalid", bus.S_RVALID, 1);
    chk("to_rresp",  bus.S_RRESP,  2'b10);
    chk("to_rdata",  bus.S_RDATA,  0);
    bus.REG_ACK = 1; bus.REG_RDATA = 32'hFFFF_FFFF;
    tick();
    bus.REG_ACK = 0;
    chk("to_late_rdata", bus.S_RDATA, 0);
    chk("to_late_rresp", bus.S_RRESP, 2'b10);
    chk("to_late_req",   bus.REG_REQ, 0);
    bus.S_RREADY = 1;
    tick();
    bus.S_RREADY = 0;
    bus.REG_ACK = 1;
    tick();
    bus.REG_ACK = 0; bus.REG_RDATA = '0;
    chk("idle_ack_req",    bus.REG_REQ,  0);
    chk("idle_ack_rvalid", bus.S_RVALID, 0);
    chk("idle_ack_bvalid", bus.S_BVALID, 0);

    // Fresh reset, then AR and AW+W together: read first
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.S_ARADDR = 32'h8; bus.S_ARVALID = 1;
    bus.S_AWADDR = 32'hC; bus.S_AWVALID = 1;
    bus.S_WDATA = 32'hA5A5_A5A5; bus.S_WSTRB = 4'h3; bus.S_WVALID = 1;
    #1;
    chk("arb1_arready", bus.S_ARREADY, 1);
    chk("arb1_awready", bus.S_AWREADY, 0);
    chk("arb1_wready",  bus.S_WREADY,  0);
    tick();
    bus.S_ARVALID = 0;
    chk("arb1_rd_we",   bus.REG_WE,   0);
    chk("arb1_rd_addr", bus.REG_ADDR, 32'h8);
    bus.REG_ACK = 1; bus.REG_RDATA = 32'h55;
    tick();
    bus.REG_ACK = 0;
    chk("arb1_rdata", bus.S_RDATA, 32'h55);
    bus.S_RREADY = 1;
    tick();
    bus.S_RREADY = 0;
    chk("arb1_wr_awready", bus.S_AWREADY, 1);
    tick();
    bus.S_AWVALID = 0; bus.S_WVALID = 0;
    chk("arb1_wr_we",    bus.REG_WE,    1);
    chk("arb1_wr_addr",  bus.REG_ADDR,  32'hC);
    chk("arb1_wr_wstrb", bus.REG_WSTRB, 4'h3);
    bus.REG_ACK = 1;
    tick();
    bus.REG_ACK = 0;
    chk("arb1_bresp", bus.S_BRESP, 2'b00);
    bus.S_BREADY = 1;
    tick();
    bus.S_BREADY = 0;

    // Second simultaneous pair: write first, with REG_ERR
    bus.S_ARADDR = 32'h8; bus.S_ARVALID = 1;
    bus.S_AWADDR = 32'h14; bus.S_AWVALID = 1;
    bus.S_WDATA = 32'h1122_3344; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1;
    #1;
    chk("arb2_arready", bus.S_ARREADY, 0);
    chk("arb2_awready", bus.S_AWREADY, 1);
    chk("arb2_wready",  bus.S_WREADY,  1);
    tick();
    bus.S_AWVALID = 0; bus.S_WVALID = 0;
    chk("arb2_wr_we",   bus.REG_WE,   1);
    chk("arb2_wr_addr", bus.REG_ADDR, 32'h14);
    bus.REG_ACK = 1; bus.REG_ERR = 1;
    tick();
    bus.REG_ACK = 0; bus.REG_ERR = 0;
    chk("arb2_bvalid", bus.S_BVALID, 1);
    chk("arb2_bresp",  bus.S_BRESP,  2'b10);
    // Backpressure: BREADY low for five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_bvalid",  bus.S_BVALID,  1);
      chk("bp_bresp",   bus.S_BRESP,   2'b10);
      chk("bp_arready", bus.S_ARREADY, 0);
    end
    bus.S_BREADY = 1;
    tick();
    bus.S_BREADY = 0;
    chk("arb2_rd_arready", bus.S_ARREADY, 1);
    tick();
    bus.S_ARVALID = 0;
    chk("arb2_rd_req", bus.REG_REQ, 1);
    chk("arb2_rd_we",  bus.REG_WE,  0);

    // Asynchronous reset in the middle of REG_RD
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    chk("midrst_req_hold", bus.REG_REQ, 0);
    rst_n = 1'b1;
    tick();

    // Clean read after reset
    bus.S_ARADDR = 32'h30; bus.S_ARVALID = 1;
    tick();
    bus.S_ARVALID = 0;
    chk("post_req",  bus.REG_REQ,  1);
    chk("post_addr", bus.REG_ADDR, 32'h30);
    bus.REG_ACK = 1; bus.REG_RDATA = 32'hCAFE_F00D;
    tick();
    bus.REG_ACK = 0;
    chk("post_rvalid", bus.S_RVALID, 1);
    chk("post_rdata",  bus.S_RDATA,  32'hCAFE_F00D);
    chk("post_rresp",  bus.S_RRESP,  2'b00);
    bus.S_RREADY = 1;
    tick();
    bus.S_RREADY = 0;
    chk("post_rvalid_drop", bus.S_RVALID, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
